alu_iter: RTL and testbench

Parametrised, handshaked successor to the combinational lab ALU. It keeps the same 5-bit opcode map and adds integer divide and remainder. Single-cycle operations return a registered result after one cycle. The multiply and divide families run on one shared iterative shift/add/subtract datapath for WIDTH cycles. It sits between the issue stage and writeback of the lab CPU, and it lets the core stall on long-latency arithmetic through valid/ready.

---
 rtl/alu_iter.sv | 189 ++++++++++++++++++
 tb/tb_alu_iter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/shift/compare ops, plus multiply and divide
// sharing one iterative shift/add/subtract datapath that runs for WIDTH cycles.
module alu_iter #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_overflow,
    output logic             alu_zero
);
    localparam int CW = SHW + 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q, r_neg_r, r_ovf_div;
    logic [WIDTH-1:0]   r_out;
    logic               r_ovf;

    // ---------------- single-cycle operations ----------------
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_sum, w_dif, w_res;
    logic [2*WIDTH-1:0] w_rotr, w_rotl;
    logic               w_ovf;

    assign w_sh   = src2[SHW-1:0];
    assign w_sum  = src1 + src2;
    assign w_dif  = src1 - src2;
    assign w_rotr = {src1, src1} >> w_sh;
    assign w_rotl = {src1, src1} << w_sh;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (alu_op)
            5'b00000: begin
                w_res = w_sum;
                w_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (w_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            5'b00001: begin
                w_res = w_dif;
                w_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (w_dif[WIDTH-1] != src1[WIDTH-1]);
            end
            5'b00010: w_res = src1 | src2;
            5'b00011: w_res = src1 & src2;
            5'b00100: w_res = src1 ^ src2;
            5'b00101: w_res = ~src1;
            5'b00110: w_res = ~(src1 & src2);
            5'b00111: w_res = ~(src1 | src2);
            5'b01000: w_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            5'b01001: w_res = {{(WIDTH-1){1'b0}}, src1 < src2};
            5'b01010: w_res = $signed(src1) >>> w_sh;
            5'b01011: w_res = src1 << w_sh;
            5'b01100: w_res = src1 >> w_sh;
            5'b01101: w_res = src1 << w_sh;
            5'b01110: w_res = w_rotr[WIDTH-1:0];
            5'b01111: w_res = w_rotl[2*WIDTH-1:WIDTH];
            default:  w_res = '0;
        endcase
    end

    // ---------------- operand preparation for the iterative ops ----------------
    logic             w_is_mul, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_is_mul = (alu_op[4:2] == 3'b100);
    assign w_is_div = (alu_op[4:2] == 3'b101);
    assign w_a_sgn  = w_is_div ? ~alu_op[0] : (alu_op[1:0] == 2'b01 || alu_op[1:0] == 2'b10);
    assign w_b_sgn  = w_is_div ? ~alu_op[0] : (alu_op[1:0] == 2'b01);
    assign w_a_neg  = w_a_sgn & src1[WIDTH-1];
    assign w_b_neg  = w_b_sgn & src2[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -src1 : src1;
    assign w_b_mag  = w_b_neg ? -src2 : src2;

    // ---------------- one iteration of the shared datapath ----------------
    // r_acc is {hi, lo}: product/multiplier for multiply, remainder/quotient for divide.
    logic [WIDTH:0]     w_msum, w_rs, w_rdiff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mnext, w_dnext, w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_iter_res;

    assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mnext   = {w_msum, r_acc[WIDTH-1:1]};
    assign w_rs      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_rs >= {1'b0, r_b});
    assign w_rdiff   = w_ge ? (w_rs - {1'b0, r_b}) : w_rs;
    assign w_dnext   = {w_rdiff[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
    assign w_acc_nxt = r_op[2] ? w_dnext : w_mnext;

    assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_iter_res = '0;
        case (r_op[2:0])
            3'b000:         w_iter_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         w_iter_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: w_iter_res = w_quo;
            default:        w_iter_res = w_rem;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = (w_is_mul || w_is_div) ? S_CALC : S_DONE;
            end
            S_CALC: if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ovf_div <= 1'b0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_op <= alu_op;
            if (w_is_mul) begin
                r_b     <= w_a_mag;
                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= 1'b0;
                r_cnt   <= CW'(WIDTH);
            end else if (w_is_div) begin
                // Divide by zero keeps the all-ones raw quotient; the remainder
                // fix-up alone restores src1.
                r_b       <= w_b_mag;
                r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                r_neg_q   <= (w_a_neg ^ w_b_neg) && (src2 != '0);
                r_neg_r   <= w_a_neg;
                r_ovf_div <= ~alu_op[0] && (src1 == MIN) && (src2 == '1);
                r_cnt     <= CW'(WIDTH);
            end else begin
                r_out <= w_res;
                r_ovf <= w_ovf;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_out <= w_iter_res;
                r_ovf <= r_op[2] & r_ovf_div;
            end
        end
    end

    assign alu_out      = r_out;
    assign alu_overflow = r_ovf;
    assign alu_zero     = (r_out == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter: latency, results, flags, hold and reset-abort.
module tb_alu_iter;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  alu_op;
    logic [31:0] src1, src2, alu_out;
    logic        alu_overflow, alu_zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high; latency counts edges including the accepting edge.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic exp_ovf, input bit do_ovf, input int exp_lat);
        int  n;
        bit  seen;
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; src1 = a; src2 = b; out_ready = 1'b1;
        chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            in_valid = 1'b0; src1 = ~a; src2 = ~b;
            seen = out_valid;
        end
        chk({tag, ".lat"}, n, exp_lat);
        chk({tag, ".out"}, alu_out, exp_out);
        if (do_ovf) chk({tag, ".ovf"}, {31'd0, alu_overflow}, {31'd0, exp_ovf});
        chk({tag, ".z"}, {31'd0, alu_zero}, {31'd0, exp_out == 32'd0});
        @(posedge clk); #1;
        chk({tag, ".end"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int  n;
        bit  seen, bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdy", {31'd0, in_ready}, 32'd1);
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        chk("rst.out", alu_out, 32'd0);
        chk("rst.ovf", {31'd0, alu_overflow}, 32'd0);
        chk("rst.z", {31'd0, alu_zero}, 32'd1);
        @(negedge clk); rst = 1'b0;

        run_op("add",    5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1, 1);
        run_op("sub",    5'b00001, 32'd5, 32'd5, 32'd0, 1'b0, 1, 1);
        run_op("subov",  5'b00001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1, 1);
        run_op("xor",    5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1, 1);
        run_op("slt",    5'b01000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1, 1);
        run_op("sltu",   5'b01001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1, 1);
        run_op("rotl",   5'b01111, 32'h80000001, 32'h21, 32'h00000003, 1'b0, 1, 1);
        run_op("rotr",   5'b01110, 32'h00000001, 32'd4, 32'h10000000, 1'b0, 1, 1);
        run_op("sra",    5'b01010, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1, 1);
        run_op("srl0",   5'b01100, 32'h80000000, 32'h20, 32'h80000000, 1'b0, 1, 1);
        run_op("badop",  5'b11111, 32'h12345678, 32'h1, 32'd0, 1'b0, 1, 1);

        run_op("mulh",   5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 33);
        run_op("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, 33);
        run_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 1, 33);
        run_op("mul",    5'b10000, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1, 33);
        run_op("mulneg", 5'b10000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 1, 33);
        run_op("mulhng", 5'b10001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 1'b0, 1, 33);

        run_op("div",    5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1, 33);
        run_op("rem",    5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1, 33);
        run_op("div2",   5'b10100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1, 33);
        run_op("rem2",   5'b10110, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 1, 33);
        run_op("divu0",  5'b10101, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 33);
        run_op("remu0",  5'b10111, 32'd7, 32'd0, 32'd7, 1'b0, 1, 33);
        run_op("div0",   5'b10100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 33);
        run_op("rem0",   5'b10110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b0, 1, 33);
        run_op("divovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1, 33);
        run_op("removf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 0, 33);
        run_op("remu",   5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, 1, 33);

        // result hold under back-pressure, with a stray request that must be ignored
        @(negedge clk);
        in_valid = 1'b1; alu_op = 5'b10101; src1 = 32'd100; src2 = 32'd7; out_ready = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            in_valid = 1'b0;
            seen = out_valid;
        end
        chk("hold.lat", n, 33);
        chk("hold.q", alu_out, 32'd14);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i < 9); alu_op = 5'b00000; src1 = 32'd1; src2 = 32'd1;
            @(posedge clk); #1;
            chk("hold.out", alu_out, 32'd14);
            chk("hold.st", {30'd0, out_valid, in_ready}, 32'b10);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold.rel", {30'd0, out_valid, in_ready}, 32'b01);
        chk("hold.keep", alu_out, 32'd14);
        @(posedge clk); #1;
        chk("hold.idle", {30'd0, out_valid, in_ready}, 32'b01);

        // reset in the middle of a divide discards it
        @(negedge clk);
        in_valid = 1'b1; alu_op = 5'b10100; src1 = 32'd1000; src2 = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("abort.mid", {30'd0, out_valid, in_ready}, 32'b00);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; alu_op = 5'b00000; src1 = 32'd2; src2 = 32'd3;
        @(posedge clk); #1;
        chk("abort.st", {30'd0, out_valid, in_ready}, 32'b01);
        chk("abort.out", alu_out, 32'd0);
        chk("abort.z", {31'd0, alu_zero}, 32'd1);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            bad |= out_valid;
        end
        chk("abort.gone", {31'd0, bad}, 32'd0);
        run_op("post", 5'b00000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
